// File: rtl/xg_tester_pkg.sv
// Shared definitions for the 10G tester: frame defaults, header field layout,
// checker FSM states and a small byte-strobe helper.
package xg_tester_pkg;

  localparam logic [31:0] MAGIC_DEFAULT     = 32'hC0DE_5A5A;
  localparam int unsigned MIN_BYTES_DEFAULT = 64;

  localparam int unsigned HDR_SEQ_LSB   = 0;
  localparam int unsigned HDR_SEQ_MSB   = 31;
  localparam int unsigned HDR_MAGIC_LSB = 32;
  localparam int unsigned HDR_MAGIC_MSB = 63;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAYLOAD,
    ST_END
  } state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Counter that adds a variable amount and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 inc_en_i,
  input  logic [INC_WIDTH-1:0] inc_i,
  output logic [WIDTH-1:0]     cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + (WIDTH+1)'(inc_i);
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_en_i) begin
      cnt_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rx_pkt_checker.sv
// Tester receive sink: validates header magic, payload pattern and sequence
// continuity of each frame and keeps saturating statistics.
module rx_pkt_checker
  import xg_tester_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned BYTE_CNT_WIDTH = 48,
  parameter logic [31:0] MAGIC          = MAGIC_DEFAULT,
  parameter int unsigned MIN_BYTES      = MIN_BYTES_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [AXI_DATA_WIDTH-1:0] s_tdata,
  input  logic [7:0]                s_tstrb,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  input  logic                      enable,
  input  logic                      clear_stats,
  output logic [CNT_WIDTH-1:0]      good_pkts,
  output logic [CNT_WIDTH-1:0]      bad_pkts,
  output logic [CNT_WIDTH-1:0]      seq_errs,
  output logic [BYTE_CNT_WIDTH-1:0] byte_cnt,
  output logic [31:0]               last_seq,
  output logic                      err_pulse
);

  localparam logic [19:0] MIN_B = 20'(MIN_BYTES);

  state_e      state_q, state_d;
  logic [31:0] seq_q, seq_d;
  logic [16:0] idx_q, idx_d;
  logic [19:0] bytes_q, bytes_d;
  logic        bad_q, bad_d;
  logic [31:0] last_seq_q;
  logic        seq_valid_q;
  logic        err_pulse_q;

  logic                      beat;
  logic [3:0]                beat_bytes;
  logic                      strb_bad;
  logic                      payload_bad;
  logic [AXI_DATA_WIDTH-1:0] mask;
  logic [AXI_DATA_WIDTH-1:0] exp_payload;
  logic                      frame_bad, good_en, bad_en, seq_err;

  assign s_tready   = enable & reset_n & (state_q != ST_END);
  assign beat       = s_tvalid & s_tready;
  assign beat_bytes = popcount8(s_tstrb);
  // Contiguous-from-bit-0 strobes are exactly those where strb & (strb+1) == 0.
  assign strb_bad   = ((s_tstrb & (s_tstrb + 8'd1)) != 8'd0) ||
                      (!s_tlast && (s_tstrb != 8'hFF));

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      mask[8*i +: 8] = {8{s_tstrb[i]}};
    end
  end

  assign exp_payload = {seq_q, 15'd0, idx_q};
  assign payload_bad = ((s_tdata ^ exp_payload) & mask) != '0;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    bytes_d = bytes_q;
    bad_d   = bad_q;
    unique case (state_q)
      ST_HDR: if (beat) begin
        seq_d   = s_tdata[HDR_SEQ_MSB:HDR_SEQ_LSB];
        idx_d   = 17'd1;
        bytes_d = {16'd0, beat_bytes};
        bad_d   = (s_tdata[HDR_MAGIC_MSB:HDR_MAGIC_LSB] != MAGIC) || (s_tstrb != 8'hFF);
        state_d = s_tlast ? ST_END : ST_PAYLOAD;
      end
      ST_PAYLOAD: if (beat) begin
        // Index stops at 2^16; a beat arriving there means the frame is too long.
        if (idx_q[16]) begin
          bad_d = 1'b1;
        end else begin
          idx_d   = idx_q + 17'd1;
          bytes_d = bytes_q + {16'd0, beat_bytes};
        end
        if (strb_bad || payload_bad) bad_d = 1'b1;
        if (s_tlast) state_d = ST_END;
      end
      ST_END:  state_d = ST_HDR;
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HDR;
      seq_q   <= '0;
      idx_q   <= '0;
      bytes_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      bytes_q <= bytes_d;
      bad_q   <= bad_d;
    end
  end

  // A clear landing in END discards the frame entirely, error pulse included.
  assign frame_bad = bad_q || (bytes_q < MIN_B);
  assign good_en   = (state_q == ST_END) && !clear_stats && !frame_bad;
  assign bad_en    = (state_q == ST_END) && !clear_stats && frame_bad;
  assign seq_err   = good_en && seq_valid_q && (seq_q != last_seq_q + 32'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_seq_q  <= '0;
      seq_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= bad_en | seq_err;
      if (clear_stats) begin
        last_seq_q  <= '0;
        seq_valid_q <= 1'b0;
      end else if (good_en) begin
        last_seq_q  <= seq_q;
        seq_valid_q <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_good_cnt (
    .clk(clk), .rst_n(reset_n), .clr_i(clear_stats),
    .inc_en_i(good_en), .inc_i(1'b1), .cnt_o(good_pkts)
  );

  sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_bad_cnt (
    .clk(clk), .rst_n(reset_n), .clr_i(clear_stats),
    .inc_en_i(bad_en), .inc_i(1'b1), .cnt_o(bad_pkts)
  );

  sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_seq_cnt (
    .clk(clk), .rst_n(reset_n), .clr_i(clear_stats),
    .inc_en_i(seq_err), .inc_i(1'b1), .cnt_o(seq_errs)
  );

  sat_counter #(.WIDTH(BYTE_CNT_WIDTH), .INC_WIDTH(20)) u_byte_cnt (
    .clk(clk), .rst_n(reset_n), .clr_i(clear_stats),
    .inc_en_i(good_en), .inc_i(bytes_q), .cnt_o(byte_cnt)
  );

  assign last_seq  = last_seq_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_rx_pkt_checker.sv
// Directed bench for rx_pkt_checker with a frame-level reference model.
module tb_rx_pkt_checker;

  localparam logic [31:0] MAGIC = 32'hC0DE_5A5A;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] s_tdata;
  logic [7:0]  s_tstrb;
  logic        s_tvalid, s_tlast, s_tready;
  logic        enable, clear_stats;
  logic [31:0] good_pkts, bad_pkts, seq_errs, last_seq;
  logic [47:0] byte_cnt;
  logic        err_pulse;

  always #5 clk = ~clk;

  rx_pkt_checker dut (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .enable(enable), .clear_stats(clear_stats),
    .good_pkts(good_pkts), .bad_pkts(bad_pkts), .seq_errs(seq_errs),
    .byte_cnt(byte_cnt), .last_seq(last_seq), .err_pulse(err_pulse)
  );

  int ncomp = 0;
  int nfail = 0;
  int pulse_seen = 0;
  bit cmp_on = 1'b0;

  // Frame-level model state
  logic [31:0] m_good, m_bad, m_seqerr, m_last;
  logic [47:0] m_bytes;
  bit          m_valid, m_pulse;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncomp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_good = '0; m_bad = '0; m_seqerr = '0; m_last = '0; m_bytes = '0;
    m_valid = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_frame(input logic [31:0] seq, input int nbytes, input bit good);
    if (good) begin
      if (m_good != '1) m_good++;
      m_bytes = m_bytes + 48'(nbytes);
      if (m_valid && (seq != m_last + 32'd1)) begin
        if (m_seqerr != '1) m_seqerr++;
        m_pulse = 1'b1;
      end
      m_last  = seq;
      m_valid = 1'b1;
    end else begin
      if (m_bad != '1) m_bad++;
      m_pulse = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("good_pkts", 64'(good_pkts), 64'(m_good));
      chk("bad_pkts",  64'(bad_pkts),  64'(m_bad));
      chk("seq_errs",  64'(seq_errs),  64'(m_seqerr));
      chk("byte_cnt",  64'(byte_cnt),  64'(m_bytes));
      chk("last_seq",  64'(last_seq),  64'(m_last));
      chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
      if (err_pulse === 1'b1) pulse_seen++;
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] st, input logic last);
    bit ok;
    @(negedge clk);
    s_tdata = d; s_tstrb = st; s_tlast = last; s_tvalid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (s_tready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 s_tvalid = 1'b0;
    if (!ok) begin
      ncomp++; nfail++;
      $display("FAIL handshake_timeout: got no s_tready expected accept at %0t", $time);
    end
  endtask

  task automatic clear_now();
    @(negedge clk);
    clear_stats = 1'b1;
    @(posedge clk);
    #1 clear_stats = 1'b0;
    model_zero();
  endtask

  task automatic send_frame(input logic [31:0] seq, input logic [31:0] magic, input int nbytes,
                            input int flip_beat, input bit zero_end, input bit weird,
                            input bit clr_end, input int stall_beat, input int abort_beat);
    int nbeats, rem;
    logic [63:0] d;
    logic [7:0]  st;
    bit good;
    nbeats = (nbytes + 7) / 8;
    good = (magic == MAGIC) && (flip_beat < 0) && !weird && (nbytes >= 64);
    for (int k = 0; k < nbeats; k++) begin
      if (k == abort_beat) begin
        @(negedge clk);
        #2 reset_n = 1'b0;
        model_zero();
        #1 chk("tready_in_reset", 64'(s_tready), 64'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        return;
      end
      d = (k == 0) ? {magic, seq} : {seq, 32'(k)};
      rem = nbytes - 8 * k;
      st = (rem >= 8) ? 8'hFF : (8'hFF >> (8 - rem));
      for (int b = 0; b < 8; b++) if (b >= rem) d[8*b +: 8] = 8'hA5;
      if (weird && k == nbeats - 1) st = 8'h0B;
      if (k == flip_beat) d[5] = ~d[5];
      if (k == stall_beat) begin
        @(negedge clk);
        enable = 1'b0;
        s_tdata = d; s_tstrb = st; s_tlast = 1'b0; s_tvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
          #1 chk("tready_disabled", 64'(s_tready), 64'd0);
          @(negedge clk);
        end
        s_tvalid = 1'b0;
        enable = 1'b1;
      end
      send_beat(d, st, (k == nbeats - 1) && !zero_end);
    end
    if (zero_end) send_beat(64'hDEAD_0000_BEEF_0000, 8'h00, 1'b1);
    if (clr_end) begin
      @(negedge clk);
      clear_stats = 1'b1;
    end
    @(posedge clk);
    #1 clear_stats = 1'b0;
    if (clr_end) model_zero();
    else         model_frame(seq, nbytes, good);
    @(posedge clk);
    #1 m_pulse = 1'b0;
  endtask

  int p0;

  initial begin
    reset_n = 1'b0; enable = 1'b1; clear_stats = 1'b0;
    s_tdata = '0; s_tstrb = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    model_zero();
    #1 chk("tready_in_reset", 64'(s_tready), 64'd0);
    cmp_on = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_good", 64'(good_pkts), 64'd0);
    chk("reset_last_seq", 64'(last_seq), 64'd0);

    // Single good 64-byte frame
    send_frame(32'd5, MAGIC, 64, -1, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("t1_good", 64'(good_pkts), 64'd1);
    chk("t1_bytes", 64'(byte_cnt), 64'd64);
    chk("t1_last", 64'(last_seq), 64'd5);
    chk("t1_seqerr", 64'(seq_errs), 64'd0);
    chk("t1_pulses", 64'(pulse_seen), 64'd0);
    clear_now();

    // Sequence gap 6 -> 8, 100-byte frames with partial last beat
    p0 = pulse_seen;
    send_frame(32'd5, MAGIC, 100, -1, 1'b0, 1'b0, 1'b0, -1, -1);
    send_frame(32'd6, MAGIC, 100, -1, 1'b0, 1'b0, 1'b0, -1, -1);
    send_frame(32'd8, MAGIC, 100, -1, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("t2_good", 64'(good_pkts), 64'd3);
    chk("t2_seqerr", 64'(seq_errs), 64'd1);
    chk("t2_bytes", 64'(byte_cnt), 64'd300);
    chk("t2_last", 64'(last_seq), 64'd8);
    chk("t2_pulses", 64'(pulse_seen - p0), 64'd1);

    // Bad magic
    p0 = pulse_seen;
    send_frame(32'd9, 32'hDEAD_BEEF, 64, -1, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("t3_bad", 64'(bad_pkts), 64'd1);
    chk("t3_good", 64'(good_pkts), 64'd3);
    chk("t3_last", 64'(last_seq), 64'd8);
    chk("t3_pulses", 64'(pulse_seen - p0), 64'd1);
    clear_now();

    // Payload corruption, runt, then recovery and boundary lengths
    send_frame(32'd9, MAGIC, 64, 3, 1'b0, 1'b0, 1'b0, -1, -1);
    send_frame(32'd10, MAGIC, 40, -1, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("t4_bad", 64'(bad_pkts), 64'd2);
    send_frame(32'd11, MAGIC, 64, -1, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("t4_good", 64'(good_pkts), 64'd1);
    send_frame(32'd12, MAGIC, 63, -1, 1'b0, 1'b0, 1'b0, -1, -1);
    send_frame(32'd12, MAGIC, 64, -1, 1'b1, 1'b0, 1'b0, -1, -1);
    send_frame(32'd13, MAGIC, 64, -1, 1'b0, 1'b1, 1'b0, -1, -1);
    send_frame(32'd13, MAGIC, 100, -1, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("t4_bad2", 64'(bad_pkts), 64'd4);
    chk("t4_good2", 64'(good_pkts), 64'd3);
    chk("t4_bytes", 64'(byte_cnt), 64'd228);
    chk("t4_seqerr", 64'(seq_errs), 64'd0);

    // Clear coinciding with END
    send_frame(32'd20, MAGIC, 64, -1, 1'b0, 1'b0, 1'b1, -1, -1);
    chk("t5_good", 64'(good_pkts), 64'd0);
    chk("t5_bytes", 64'(byte_cnt), 64'd0);
    chk("t5_last", 64'(last_seq), 64'd0);
    send_frame(32'd77, MAGIC, 64, -1, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("t5_seqerr", 64'(seq_errs), 64'd0);
    chk("t5_last2", 64'(last_seq), 64'd77);

    // Enable stall mid-frame, then reset mid-frame
    send_frame(32'd78, MAGIC, 64, -1, 1'b0, 1'b0, 1'b0, 4, -1);
    chk("t6_good", 64'(good_pkts), 64'd2);
    chk("t6_last", 64'(last_seq), 64'd78);
    send_frame(32'd79, MAGIC, 64, -1, 1'b0, 1'b0, 1'b0, -1, 3);
    chk("t6_rst_good", 64'(good_pkts), 64'd0);
    chk("t6_rst_bytes", 64'(byte_cnt), 64'd0);
    send_frame(32'd200, MAGIC, 64, -1, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("t6_good2", 64'(good_pkts), 64'd1);
    chk("t6_seqerr", 64'(seq_errs), 64'd0);
    chk("t6_last2", 64'(last_seq), 64'd200);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

endmodule
